// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types: frame FSM states and the scan-code prefix bytes.
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} Ps2_Frame_State;

  localparam logic [7:0] SC_EXTENDED = 8'hE0;
  localparam logic [7:0] SC_BREAK    = 8'hF0;
endpackage

// File: rtl/ps2_keyboard_receiver_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, 11-bit frame FSM, timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       Fast_Clock,
  input  logic       Reset,
  input  logic       PS2_Clk,
  input  logic       PS2_Data,
  output logic       byte_done,
  output logic [7:0] rx_byte,
  output logic       frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   sync_clk_prev;
  logic                   sync_clk, data, fall;

  Ps2_Frame_State state, state_n;
  logic [2:0]     bit_cnt;
  logic [7:0]     shift;
  logic           par;
  logic [TW-1:0]  tcnt;
  logic           timeout, done_d, err_d, good;

  // Synchronisers reset high so releasing Reset never manufactures a falling edge.
  always_ff @(posedge Fast_Clock or posedge Reset)
    if (Reset) begin
      clk_sync      <= '1;
      dat_sync      <= '1;
      sync_clk_prev <= 1'b1;
    end else begin
      clk_sync      <= {clk_sync[SYNC_STAGES-2:0], PS2_Clk};
      dat_sync      <= {dat_sync[SYNC_STAGES-2:0], PS2_Data};
      sync_clk_prev <= sync_clk;
    end

  assign sync_clk = clk_sync[SYNC_STAGES-1];
  assign data     = dat_sync[SYNC_STAGES-1];
  assign fall     = sync_clk_prev & ~sync_clk;
  assign good     = (^shift ^ par) & data;
  assign timeout  = (state != IDLE) && !fall && (tcnt == T_LAST);

  always_ff @(posedge Fast_Clock or posedge Reset)
    if (Reset) state <= IDLE;
    else       state <= state_n;

  always_comb begin
    state_n = state;
    if (timeout) state_n = IDLE;
    else if (fall)
      case (state)
        IDLE:    if (!data) state_n = DATA;
        DATA:    if (bit_cnt == 3'd7) state_n = PARITY;
        PARITY:  state_n = STOP;
        STOP:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
  end

  always_comb begin
    done_d = 1'b0;
    err_d  = timeout;
    if (fall && state == IDLE && data) err_d = 1'b1;
    if (fall && state == STOP) begin
      done_d = good;
      err_d  = !good;
    end
  end

  always_ff @(posedge Fast_Clock or posedge Reset)
    if (Reset) begin
      bit_cnt   <= '0;
      shift     <= '0;
      par       <= 1'b0;
      tcnt      <= '0;
      byte_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_done <= done_d;
      frame_err <= err_d;
      if (fall || state == IDLE) tcnt <= '0;
      else if (tcnt != '1)       tcnt <= tcnt + 1'b1;
      if (fall)
        case (state)
          IDLE:    bit_cnt <= '0;
          DATA: begin
            shift   <= {data, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY:  par <= data;
          default: ;
        endcase
    end

  assign rx_byte = shift;
endmodule

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 keyboard receiver: frame reception plus make/break/E0 decoding into the held-key byte.
module ps2_keyboard_receiver
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       Fast_Clock,
  input  logic       Reset,
  input  logic       PS2_Clk,
  input  logic       PS2_Data,
  output logic [7:0] Kb_Byte,
  output logic       Kb_Extended,
  output logic       Kb_Valid,
  output logic       Frame_Error
);
  logic       byte_done, frame_err;
  logic [7:0] rx_byte;
  logic       ext_pending, brk_pending;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_frame_rx (
    .Fast_Clock(Fast_Clock),
    .Reset     (Reset),
    .PS2_Clk   (PS2_Clk),
    .PS2_Data  (PS2_Data),
    .byte_done (byte_done),
    .rx_byte   (rx_byte),
    .frame_err (frame_err)
  );

  assign Frame_Error = frame_err;

  // A release only clears the outputs when it names the key actually held.
  always_ff @(posedge Fast_Clock or posedge Reset)
    if (Reset) begin
      Kb_Byte     <= '0;
      Kb_Extended <= 1'b0;
      Kb_Valid    <= 1'b0;
      ext_pending <= 1'b0;
      brk_pending <= 1'b0;
    end else begin
      Kb_Valid <= 1'b0;
      if (frame_err) begin
        ext_pending <= 1'b0;
        brk_pending <= 1'b0;
      end else if (byte_done) begin
        if (rx_byte == SC_EXTENDED)   ext_pending <= 1'b1;
        else if (rx_byte == SC_BREAK) brk_pending <= 1'b1;
        else if (brk_pending) begin
          if (rx_byte == Kb_Byte && ext_pending == Kb_Extended) begin
            Kb_Byte     <= '0;
            Kb_Extended <= 1'b0;
          end
          ext_pending <= 1'b0;
          brk_pending <= 1'b0;
        end else begin
          Kb_Byte     <= rx_byte;
          Kb_Extended <= ext_pending;
          Kb_Valid    <= 1'b1;
          ext_pending <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Directed bench for ps2_keyboard_receiver: make/break/extended decoding, frame errors, timeout, reset.
module tb_ps2_keyboard_receiver;
  localparam int TO = 500;

  logic       Fast_Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       PS2_Clk = 1'b1;
  logic       PS2_Data = 1'b1;
  logic [7:0] Kb_Byte;
  logic       Kb_Extended, Kb_Valid, Frame_Error;

  int vectors = 0, miscompares = 0;
  int valid_cnt = 0, err_cnt = 0;
  int v0, e0;

  ps2_keyboard_receiver #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .Fast_Clock (Fast_Clock),
    .Reset      (Reset),
    .PS2_Clk    (PS2_Clk),
    .PS2_Data   (PS2_Data),
    .Kb_Byte    (Kb_Byte),
    .Kb_Extended(Kb_Extended),
    .Kb_Valid   (Kb_Valid),
    .Frame_Error(Frame_Error)
  );

  always #5 Fast_Clock = ~Fast_Clock;

  always @(negedge Fast_Clock) begin
    if (Kb_Valid)    valid_cnt++;
    if (Frame_Error) err_cnt++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge Fast_Clock) PS2_Data = b;
    repeat (10) @(negedge Fast_Clock);
    PS2_Clk = 1'b0;
    repeat (20) @(negedge Fast_Clock);
    PS2_Clk = 1'b1;
    repeat (10) @(negedge Fast_Clock);
  endtask

  task automatic send(input logic [7:0] b, input logic bad_par = 1'b0, input logic bad_stop = 1'b0);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~^b ^ bad_par);
    ps2_bit(~bad_stop);
    PS2_Data = 1'b1;
    repeat (10) @(negedge Fast_Clock);
  endtask

  task automatic snap();
    v0 = valid_cnt;
    e0 = err_cnt;
  endtask

  initial begin
    logic [7:0] f0 = 8'hF0;
    repeat (5) @(negedge Fast_Clock);
    check("rst_byte", Kb_Byte, 0);
    check("rst_ext", Kb_Extended, 0);
    check("rst_valid", Kb_Valid, 0);
    check("rst_err", Frame_Error, 0);
    Reset = 1'b0;
    repeat (5) @(negedge Fast_Clock);

    snap(); send(8'h1C);
    check("make_byte", Kb_Byte, 8'h1C);
    check("make_ext", Kb_Extended, 0);
    check("make_valid", valid_cnt - v0, 1);
    check("make_err", err_cnt - e0, 0);

    snap(); send(8'hF0); send(8'h1C);
    check("brk_byte", Kb_Byte, 0);
    check("brk_valid", valid_cnt - v0, 0);

    send(8'h1C); snap(); send(8'hF0); send(8'h2A);
    check("brk_other_byte", Kb_Byte, 8'h1C);
    check("brk_other_valid", valid_cnt - v0, 0);

    snap(); send(8'hE0); send(8'h75);
    check("ext_byte", Kb_Byte, 8'h75);
    check("ext_flag", Kb_Extended, 1);
    check("ext_valid", valid_cnt - v0, 1);

    send(8'hF0); send(8'h75);
    check("plain_brk_byte", Kb_Byte, 8'h75);
    check("plain_brk_ext", Kb_Extended, 1);

    send(8'hE0); send(8'hF0); send(8'h75);
    check("ext_brk_byte", Kb_Byte, 0);
    check("ext_brk_ext", Kb_Extended, 0);

    send(8'h1C); snap(); send(8'h1C, 1'b1, 1'b0);
    check("par_err", err_cnt - e0, 1);
    check("par_err_byte", Kb_Byte, 8'h1C);
    check("par_err_valid", valid_cnt - v0, 0);

    snap(); send(8'h2A, 1'b0, 1'b1);
    check("stop_err", err_cnt - e0, 1);
    check("stop_err_byte", Kb_Byte, 8'h1C);

    snap(); send(8'hF0); send(8'h33, 1'b1, 1'b0); send(8'h1C);
    check("pend_clr_valid", valid_cnt - v0, 1);
    check("pend_clr_err", err_cnt - e0, 1);
    check("pend_clr_byte", Kb_Byte, 8'h1C);

    // Start bit plus four data bits, then the clock stalls.
    snap();
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (TO + 100) @(negedge Fast_Clock);
    check("timeout_err", err_cnt - e0, 1);
    snap(); send(8'h3A);
    check("after_to_byte", Kb_Byte, 8'h3A);
    check("after_to_valid", valid_cnt - v0, 1);
    check("after_to_err", err_cnt - e0, 0);

    // Reset after five data bits of F0; the leftover bits are all 1s and
    // each one lands in IDLE as a bad start bit.
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(f0[i]);
    @(negedge Fast_Clock) Reset = 1'b1;
    #1;
    check("mid_rst_byte", Kb_Byte, 0);
    check("mid_rst_ext", Kb_Extended, 0);
    check("mid_rst_flags", {Kb_Valid, Frame_Error}, 0);
    repeat (3) @(negedge Fast_Clock);
    Reset = 1'b0;
    snap();
    repeat (10) @(negedge Fast_Clock);
    check("rel_no_err", err_cnt - e0, 0);
    for (int i = 5; i < 8; i++) ps2_bit(f0[i]);
    ps2_bit(~^f0);
    ps2_bit(1'b1);
    repeat (10) @(negedge Fast_Clock);
    check("rest_valid", valid_cnt - v0, 0);
    check("rest_err", err_cnt - e0, 5);
    check("rest_byte", Kb_Byte, 0);
    snap(); send(8'h16);
    check("post_rst_byte", Kb_Byte, 8'h16);
    check("post_rst_valid", valid_cnt - v0, 1);
    check("post_rst_err", err_cnt - e0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ps2_keyboard_receiver.md
Name: ps2_keyboard_receiver

Overview:
Receives PS/2 keyboard frames and decodes make, break and extended scan-code sequences. Presents the currently held key code on Kb_Byte, which is the byte the I/O module polls in keyboard-input mode (IO = 2). Sits between the board PS/2 pins and the I/O module, clocked by Fast_Clock.

Parameters:
TIMEOUT_CYCLES, 100000, Fast_Clock cycles without a PS/2 clock falling edge before a partial frame is abandoned (2 ms at 50 MHz).
SYNC_STAGES, 2, flip-flop depth of the PS2_Clk/PS2_Data synchronisers (minimum 2).

Ports:
Fast_Clock  in  1  system clock; all logic on posedge.
Reset  in  1  reset, asynchronous, active-high.
PS2_Clk  in  1  raw PS/2 clock from the pin (asynchronous, idles high).
PS2_Data  in  1  raw PS/2 data from the pin (asynchronous, idles high).
Kb_Byte  out  8  make code of the currently held key; 0 when no key is held.
Kb_Extended  out  1  1 when the held key was prefixed by E0.
Kb_Valid  out  1  one-cycle pulse on every accepted make code, including typematic repeats.
Frame_Error  out  1  one-cycle pulse on a start, parity, stop or timeout error.

Behaviour:
- Reset (async): synchroniser flops = 1, state IDLE, bit_cnt = 0, shift = 0, timeout counter = 0, ext_pending = 0, brk_pending = 0. Kb_Byte = 0, Kb_Extended = 0, Kb_Valid = 0, Frame_Error = 0.
- Reset asserted mid-frame discards the partial frame. Because the synchronisers reset to 1, no false falling edge is seen after release.
- Edge detect: fall = sync_clk_prev & ~sync_clk. Data is sampled (synchronised PS2_Data) only in a cycle where fall = 1.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data = 0, go to DATA with bit_cnt = 0. On fall with data = 1, pulse Frame_Error and stay in IDLE.
  - DATA: on fall, shift = {data, shift[7:1]} (LSB first) and bit_cnt++. After the 8th bit (bit_cnt = 7 on entry), go to PARITY.
  - PARITY: on fall, latch par = data, go to STOP.
  - STOP: on fall, the frame is good iff (^shift ^ par) = 1 (odd parity) and data = 1. Good frame: emit byte_done for 1 cycle. Bad frame: pulse Frame_Error. Either way return to IDLE.
- Timeout: the counter clears on every fall and in IDLE, and increments otherwise. In DATA/PARITY/STOP, reaching TIMEOUT_CYCLES-1 forces IDLE, pulses Frame_Error, and clears ext_pending and brk_pending.
- Any Frame_Error also clears ext_pending and brk_pending. Kb_Byte and Kb_Extended are unchanged by errors.
- Decoder (acts on byte_done):
  - 8'hE0: ext_pending = 1.
  - 8'hF0: brk_pending = 1.
  - Other byte with brk_pending = 1 (release): if byte == Kb_Byte and ext_pending == Kb_Extended, set Kb_Byte = 0 and Kb_Extended = 0; otherwise outputs are unchanged. Clear both pendings. No Kb_Valid.
  - Other byte with brk_pending = 0 (make): Kb_Byte = byte, Kb_Extended = ext_pending, Kb_Valid = 1 for one cycle, clear ext_pending.
  - A repeated identical make re-pulses Kb_Valid; Kb_Byte stays stable.
  - A new make while another key is held overwrites Kb_Byte (last key wins).
- Latency: Kb_Byte, Kb_Extended and Kb_Valid update on the 2nd posedge after the posedge where the stop-bit fall is detected. That is SYNC_STAGES+2 cycles after the pin edge.
- Kb_Byte changes only on posedge, so it is stable at the I/O module's negedge sampling point.
- Width rules: bit_cnt is 3 bits. The timeout counter is $clog2(TIMEOUT_CYCLES) bits and saturates without wrapping.

Decomposition:
- Package ps2_pkg:
  - typedef enum Ps2_Frame_State {IDLE, DATA, PARITY, STOP}.
  - Constants SC_EXTENDED = 8'hE0 and SC_BREAK = 8'hF0.
- Sub-module ps2_frame_rx: synchronisers, edge detect, frame FSM and timeout. Outputs byte_done, rx_byte[7:0] and frame_err.
- The top level holds the make/break/extended decoder and the output registers.

Test Plan:
- Make: send frame 8'h1C (parity 0, stop 1) -> Kb_Valid pulses once, Kb_Byte = 8'h1C, Kb_Extended = 0, Frame_Error stays 0.
- Break: then send F0, 1C -> Kb_Byte returns to 8'h00 with no Kb_Valid. Then send F0, 2A (key not held) -> Kb_Byte is unchanged.
- Extended: send E0, 75 -> Kb_Byte = 8'h75, Kb_Extended = 1. Then E0, F0, 75 -> Kb_Byte = 0, Kb_Extended = 0. Plain F0, 75 while E0-75 is held -> no change.
- Errors: send 8'h1C with the parity bit inverted -> Frame_Error pulses and Kb_Byte keeps its old value. Send a stop bit of 0 -> Frame_Error. Send F0 then a bad frame then 1C -> treated as a make (pending cleared), Kb_Valid pulses.
- Timeout: stop the PS/2 clock after 4 data bits for TIMEOUT_CYCLES cycles (use 500 in simulation) -> Frame_Error pulses and FSM is back in IDLE. A following full 8'h3A frame decodes correctly.
- Reset mid-frame: assert Reset after the 5th bit -> all outputs 0 immediately (asynchronous). Complete the remaining bits after release -> no Kb_Valid and no false Frame_Error from the reset edge. The next valid 8'h16 frame decodes.
